receiver: RTL and testbench
===========================

# receiver

Serial-to-parallel receiver for the single-wire link driven by the 55-bit transmitter. It samples `S_Data` once per `Clk_S` edge, detects a start bit, and shifts in one data word (LSB first). It presents the word on a parallel valid/ready interface to the router core and flags words lost to back-pressure. It sits at the link input of each router port, in the same `Clk_S` domain as the transmitter.

## Interface
- `DATA_WIDTH`, default 55: payload bits per frame; legal range 2..63; bit counter is 6 bits.
- `Clk_S`  in  1  link clock; all flops rise-edge.
- `Rst_n`  in  1  reset, asynchronous, active-low.
- `S_Data`  in  1  serial line, synchronous to `Clk_S`; no synchroniser.
- `RX_Ready`  in  1  consumer accepts `RX_Data` this cycle.
- `RX_Data`  out  DATA_WIDTH  received word.
- `RX_Data_Valid`  out  1  `RX_Data` holds an unconsumed word.
- `RX_Busy`  out  1  frame reception in progress.
- `RX_Overrun`  out  1  one-cycle pulse: completed frame dropped.
- `RX_Parity_Err`  out  1  one-cycle pulse: parity mismatch; constant 0 without `RX_PARITY_EN`.

## Operation
- Line idles low. Frame is a start bit (`1`), then `DATA_WIDTH` data bits, bit 0 first, then the parity bit if enabled. There is no stop bit.
- FSM states:
  - IDLE: `S_Data`=1 at an edge moves to DATA and clears bit counter to 0.
  - DATA: each edge shifts `S_Data` into shift register position `counter` and increments counter. The edge sampling bit `DATA_WIDTH-1` moves to PARITY (macro on) or completes the frame and returns to IDLE (macro off).
  - PARITY: one edge samples the parity bit, completes the frame, and returns to IDLE.
- Completion is evaluated in the completion edge, using the incoming bit:
  - If `RX_Data_Valid`=0 or `RX_Ready`=1: load `RX_Data` with the assembled word and set `RX_Data_Valid`=1.
  - Otherwise: discard the word, leave `RX_Data` unchanged, and pulse `RX_Overrun` high for one cycle.
- Handshake: the word is consumed on an edge with `RX_Data_Valid`=1 and `RX_Ready`=1. `RX_Data_Valid` then clears, unless a completion loads a new word on the same edge, in which case it stays 1.
- `RX_Data` is stable while `RX_Data_Valid`=1 and not consumed.
- A start bit is accepted on the edge immediately after completion (back-to-back frames).
- `RX_Busy`=1 in DATA and PARITY.
- The shift register is not cleared between frames. Every bit is overwritten before use.

## Timing
- Reset values: FSM IDLE, counter 0, `RX_Data`=0, `RX_Data_Valid`=0, `RX_Busy`=0, `RX_Overrun`=0, `RX_Parity_Err`=0.
- Reset asserted mid-frame aborts the frame. The partial word is never presented.
- With the start bit sampled at edge T, data bit i is sampled at edge T+1+i.
- `RX_Data_Valid` rises after:
  - edge T+DATA_WIDTH (T+55 at default), macro off;
  - edge T+DATA_WIDTH+1, macro on.
- Minimum frame period: DATA_WIDTH+1 cycles (macro off), DATA_WIDTH+2 (macro on).
- `RX_Overrun` and `RX_Parity_Err` are high exactly one cycle, the cycle after the completion edge.
- All outputs are registered. No combinational path from any input to any output.

## Configuration
- `RX_PARITY_EN` defined:
  - Frame carries one even-parity bit after the data, so XOR of data and parity bits is 0.
  - On mismatch, the word is still delivered (or dropped by overrun rules) and `RX_Parity_Err` pulses for one cycle.
- `RX_PARITY_EN` undefined:
  - No PARITY state; frame matches the existing transmitter format.
  - `RX_Parity_Err` is tied 0.

## Test plan
- Single frame, macro off, `RX_Ready`=1: start then 55'h2A_AAAA_AAAA_AAAA LSB first -> `RX_Data_Valid` high after edge T+55, `RX_Data`=55'h2A_AAAA_AAAA_AAAA, cleared next edge.
- Back-to-back frames 55'h0 then 55'h7F_FFFF_FFFF_FFFF with no idle cycle, `RX_Ready`=1 -> both words delivered in order, no `RX_Overrun`.
- `RX_Ready`=0 held, two frames 55'h1 and 55'h2 -> `RX_Data` stays 55'h1, `RX_Overrun` pulses once after second completion. Raising `RX_Ready` then clears `RX_Data_Valid`.
- Completion coincident with consume (`RX_Valid`=1, `RX_Ready`=1 on completion edge) -> `RX_Data` updates to new word, `RX_Data_Valid` stays 1, no overrun.
- `Rst_n` low at edge T+20 of a frame, released, line held low -> all outputs 0, no valid; a subsequent frame 55'h5 is received correctly.
- Macro on: frame 55'h3 with parity bit 1 -> `RX_Data`=55'h3, `RX_Parity_Err` pulses once; same frame with parity bit 0 -> no error pulse.

Source files
------------

// File: rtl/receiver.sv
// receiver: serial-to-parallel receiver for the single-wire link.
//
// Samples S_Data on every rising Clk_S edge. The line idles low; a frame is a
// start bit (1), DATA_WIDTH data bits LSB first and, when RX_PARITY_EN is
// defined, one even-parity bit. There is no stop bit. Completed words are
// offered on a valid/ready interface. A word that completes while the previous
// one is still unconsumed is dropped.
//
// Configuration macro: RX_PARITY_EN (undefined by default) adds the PARITY
// state and drives RX_Parity_Err. Without it RX_Parity_Err is tied low.
//
// Ports:
//   Clk_S          in   link clock (rising edge)
//   Rst_n          in   asynchronous active-low reset
//   S_Data         in   serial line, already synchronous to Clk_S
//   RX_Ready       in   consumer accepts RX_Data this cycle
//   RX_Data        out  received word
//   RX_Data_Valid  out  RX_Data holds an unconsumed word
//   RX_Busy        out  frame reception in progress
//   RX_Overrun     out  one-cycle pulse: completed frame dropped
//   RX_Parity_Err  out  one-cycle pulse: parity mismatch
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | line idle, waiting for a start bit
// DATA   | shifting in data bit number cnt
// PARITY | sampling the parity bit (RX_PARITY_EN only)

module receiver #(
    parameter int DATA_WIDTH = 55
) (
    input  logic                  Clk_S,
    input  logic                  Rst_n,
    input  logic                  S_Data,
    input  logic                  RX_Ready,
    output logic [DATA_WIDTH-1:0] RX_Data,
    output logic                  RX_Data_Valid,
    output logic                  RX_Busy,
    output logic                  RX_Overrun,
    output logic                  RX_Parity_Err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam logic [5:0] LAST = 6'(DATA_WIDTH - 1);

    state_t                  state;
    logic [5:0]              cnt;
    logic [DATA_WIDTH-1:0]   shreg;
    logic [DATA_WIDTH-1:0]   word;
    logic                    done;
    logic                    perr_now;

    // Completion is decided on the edge that samples the final bit of the
    // frame, so the assembled word includes the bit arriving on that edge.
    always_comb begin
        word     = shreg;
        done     = 1'b0;
        perr_now = 1'b0;
`ifdef RX_PARITY_EN
        if (state == PARITY) begin
            done     = 1'b1;
            perr_now = ^{S_Data, shreg};
        end
`else
        if (state == DATA && cnt == LAST) begin
            done                 = 1'b1;
            word[DATA_WIDTH-1]   = S_Data;
        end
`endif
    end

    always_ff @(posedge Clk_S or negedge Rst_n) begin
        if (!Rst_n) begin
            state         <= IDLE;
            cnt           <= 6'd0;
            shreg         <= '0;
            RX_Data       <= '0;
            RX_Data_Valid <= 1'b0;
            RX_Busy       <= 1'b0;
            RX_Overrun    <= 1'b0;
            RX_Parity_Err <= 1'b0;
        end else begin
            RX_Overrun    <= 1'b0;
            RX_Parity_Err <= 1'b0;

            case (state)
                IDLE: begin
                    if (S_Data) begin
                        state   <= DATA;
                        cnt     <= 6'd0;
                        RX_Busy <= 1'b1;
                    end
                end
                DATA: begin
                    shreg[cnt] <= S_Data;
                    cnt        <= cnt + 6'd1;
                    if (cnt == LAST) begin
`ifdef RX_PARITY_EN
                        state   <= PARITY;
`else
                        state   <= IDLE;
                        RX_Busy <= 1'b0;
`endif
                    end
                end
                PARITY: begin
                    state   <= IDLE;
                    RX_Busy <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    RX_Busy <= 1'b0;
                end
            endcase

            // A consume and a new load on the same edge keep valid high.
            if (done) begin
                if (!RX_Data_Valid || RX_Ready) begin
                    RX_Data       <= word;
                    RX_Data_Valid <= 1'b1;
                end else begin
                    RX_Overrun    <= 1'b1;
                end
                RX_Parity_Err <= perr_now;
            end else if (RX_Data_Valid && RX_Ready) begin
                RX_Data_Valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_receiver.sv
// tb_receiver: self-checking bench for receiver (DATA_WIDTH = 55).
// Directed table of frames, hand-written corner sequences, then a randomized
// line/ready stream checked against a frame-level reference model.

module tb_receiver;

    localparam int N = 55;
`ifdef RX_PARITY_EN
    localparam int FL = N + 1;
`else
    localparam int FL = N;
`endif
    localparam int L = 1500;

    logic         Clk_S = 1'b0;
    logic         Rst_n = 1'b0;
    logic         S_Data = 1'b0;
    logic         RX_Ready = 1'b0;
    logic [N-1:0] RX_Data;
    logic         RX_Data_Valid;
    logic         RX_Busy;
    logic         RX_Overrun;
    logic         RX_Parity_Err;

    receiver #(.DATA_WIDTH(N)) dut (
        .Clk_S         (Clk_S),
        .Rst_n         (Rst_n),
        .S_Data        (S_Data),
        .RX_Ready      (RX_Ready),
        .RX_Data       (RX_Data),
        .RX_Data_Valid (RX_Data_Valid),
        .RX_Busy       (RX_Busy),
        .RX_Overrun    (RX_Overrun),
        .RX_Parity_Err (RX_Parity_Err)
    );

    always #5 Clk_S = ~Clk_S;

    int n_pass = 0;
    int n_total = 0;
    logic pre_valid, pre_busy;

    typedef struct {
        logic [N-1:0] word;
        bit           rdy;
        bit           rdy_last;
        logic [N-1:0] exp_data;
        bit           exp_valid;
        bit           exp_ovr;
    } vec_t;

    vec_t vecs[7];

    // random-phase stimulus and expectations, indexed by clock edge
    bit           line_a[L];
    bit           rdy_a[L];
    bit           comp_a[L];
    bit           busy_a[L];
    bit           perr_a[L];
    logic [N-1:0] cw_a[L];
    logic [N-1:0] ed_a[L];
    bit           ev_a[L];
    bit           eo_a[L];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    endtask

    // Drive inputs for the next rising edge, then return on the following
    // falling edge so outputs reflect that rising edge.
    task automatic step(input logic sd, input logic rdy);
        S_Data   = sd;
        RX_Ready = rdy;
        @(posedge Clk_S);
        @(negedge Clk_S);
    endtask

    task automatic send_frame(input logic [N-1:0] w, input bit rdy, input bit rdy_last,
                              input bit pflip);
        step(1'b1, rdy);
        for (int i = 0; i < N - 1; i++) step(w[i], rdy);
`ifdef RX_PARITY_EN
        step(w[N-1], rdy);
        pre_valid = RX_Data_Valid;
        pre_busy  = RX_Busy;
        step((^w) ^ pflip, rdy_last);
`else
        pre_valid = RX_Data_Valid;
        pre_busy  = RX_Busy;
        if (pflip) $display("note: parity flip ignored without parity");
        step(w[N-1], rdy_last);
`endif
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_data"},  64'(RX_Data), 64'd0);
        chk({nm, "_valid"}, 64'(RX_Data_Valid), 64'd0);
        chk({nm, "_busy"},  64'(RX_Busy), 64'd0);
        chk({nm, "_ovr"},   64'(RX_Overrun), 64'd0);
        chk({nm, "_perr"},  64'(RX_Parity_Err), 64'd0);
    endtask

    initial begin
        logic [N-1:0] w;
        logic [63:0]  t;
        int           s, c;
        bit           pf, mvalid;
        logic [N-1:0] mdata;

        vecs[0] = '{55'h2A_AAAA_AAAA_AAAA, 1, 1, 55'h2A_AAAA_AAAA_AAAA, 1, 0};
        vecs[1] = '{55'h0,                 1, 1, 55'h0,                 1, 0};
        vecs[2] = '{55'h7F_FFFF_FFFF_FFFF, 1, 1, 55'h7F_FFFF_FFFF_FFFF, 1, 0};
        vecs[3] = '{55'h1,                 1, 1, 55'h1,                 1, 0};
        vecs[4] = '{55'h2,                 0, 0, 55'h1,                 1, 1};
        vecs[5] = '{55'h3,                 0, 0, 55'h1,                 1, 1};
        vecs[6] = '{55'h5,                 0, 1, 55'h5,                 1, 0};

        // reset values
        @(negedge Clk_S);
        @(negedge Clk_S);
        chk_all_zero("reset_in");
        Rst_n = 1'b1;
        step(1'b0, 1'b0);
        chk_all_zero("reset_out");

        // directed frames, back to back
        for (int k = 0; k < 7; k++) begin
            send_frame(vecs[k].word, vecs[k].rdy, vecs[k].rdy_last, 1'b0);
            if (k == 0) chk("first_valid_before_last_edge", 64'(pre_valid), 64'd0);
            chk($sformatf("vec%0d_busy_before", k), 64'(pre_busy), 64'd1);
            chk($sformatf("vec%0d_data", k),  64'(RX_Data), 64'(vecs[k].exp_data));
            chk($sformatf("vec%0d_valid", k), 64'(RX_Data_Valid), 64'(vecs[k].exp_valid));
            chk($sformatf("vec%0d_ovr", k),   64'(RX_Overrun), 64'(vecs[k].exp_ovr));
            chk($sformatf("vec%0d_busy", k),  64'(RX_Busy), 64'd0);
            chk($sformatf("vec%0d_perr", k),  64'(RX_Parity_Err), 64'd0);
        end

        // consume clears valid; pulses last one cycle
        step(1'b0, 1'b1);
        chk("consume_valid", 64'(RX_Data_Valid), 64'd0);
        chk("consume_data_hold", 64'(RX_Data), 64'h5);
        chk("ovr_one_cycle", 64'(RX_Overrun), 64'd0);

        // unconsumed word holds, then raising ready clears it
        send_frame(55'h1, 0, 0, 0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("hold_valid", 64'(RX_Data_Valid), 64'd1);
        chk("hold_data", 64'(RX_Data), 64'h1);
        step(1'b0, 1'b1);
        chk("ready_clears_valid", 64'(RX_Data_Valid), 64'd0);

        // reset mid-frame at edge T+20
        w = 55'h7F_0F0F_0F0F_0F0F;
        step(1'b1, 1'b1);
        for (int i = 0; i < 19; i++) step(w[i], 1'b1);
        chk("mid_busy", 64'(RX_Busy), 64'd1);
        Rst_n = 1'b0;
        #1;
        chk("async_busy_clear", 64'(RX_Busy), 64'd0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        Rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        chk_all_zero("after_abort");
        send_frame(55'h5, 1, 1, 0);
        chk("after_abort_data", 64'(RX_Data), 64'h5);
        chk("after_abort_valid", 64'(RX_Data_Valid), 64'd1);

`ifdef RX_PARITY_EN
        step(1'b0, 1'b1);
        send_frame(55'h3, 1, 1, 1);
        chk("par_bad_data", 64'(RX_Data), 64'h3);
        chk("par_bad_err", 64'(RX_Parity_Err), 64'd1);
        step(1'b0, 1'b1);
        chk("par_err_one_cycle", 64'(RX_Parity_Err), 64'd0);
        send_frame(55'h3, 1, 1, 0);
        chk("par_good_data", 64'(RX_Data), 64'h3);
        chk("par_good_err", 64'(RX_Parity_Err), 64'd0);
`endif

        // randomized stream: frames at random starts, random ready
        for (int e = 0; e < L; e++) begin
            line_a[e] = 0; comp_a[e] = 0; busy_a[e] = 0; perr_a[e] = 0;
            cw_a[e] = '0; rdy_a[e] = bit'($urandom_range(0, 1));
        end
        s = 2;
        while (s + FL + 1 < L) begin
            t = {$urandom, $urandom};
            w = t[N-1:0];
`ifdef RX_PARITY_EN
            pf = ($urandom_range(0, 3) == 0);
            line_a[s+N+1] = (^w) ^ pf;
`else
            pf = 0;
`endif
            line_a[s] = 1;
            for (int i = 0; i < N; i++) line_a[s+1+i] = w[i];
            c = s + FL;
            comp_a[c] = 1;
            cw_a[c]   = w;
            perr_a[c] = pf;
            for (int e = s; e < c; e++) busy_a[e] = 1;
            s = c + 1 + int'($urandom_range(0, 3));
        end

        mvalid = 0;
        mdata  = '0;
        for (int e = 0; e < L; e++) begin
            eo_a[e] = 0;
            if (comp_a[e]) begin
                if (!mvalid || rdy_a[e]) begin
                    mdata  = cw_a[e];
                    mvalid = 1;
                end else begin
                    eo_a[e] = 1;
                end
            end else if (mvalid && rdy_a[e]) begin
                mvalid = 0;
            end
            ed_a[e] = mdata;
            ev_a[e] = mvalid;
        end

        Rst_n = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        Rst_n = 1'b1;
        for (int e = 0; e < L; e++) begin
            step(line_a[e], rdy_a[e]);
            chk($sformatf("rnd%0d_data", e),  64'(RX_Data), 64'(ed_a[e]));
            chk($sformatf("rnd%0d_valid", e), 64'(RX_Data_Valid), 64'(ev_a[e]));
            chk($sformatf("rnd%0d_busy", e),  64'(RX_Busy), 64'(busy_a[e]));
            chk($sformatf("rnd%0d_ovr", e),   64'(RX_Overrun), 64'(eo_a[e]));
            chk($sformatf("rnd%0d_perr", e),  64'(RX_Parity_Err), 64'(perr_a[e] & comp_a[e]));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
